// File: rtl/ext_sync_filter_if.sv
// Pin-side bundle for ext_sync_filter: raw pins and controls in, filtered levels, edge pulses and flags out.
// No flow control; every signal is sampled or updated once per sys_clk cycle.
interface ext_sync_filter_if #(
  parameter int CH     = 4,
  parameter int FILT_W = 4
);
  logic [CH-1:0]     t;
  logic [FILT_W-1:0] filt_len;
  logic [2*CH-1:0]   edge_sel;
  logic [CH-1:0]     flag_clr;
  logic [CH-1:0]     t_filt;
  logic [CH-1:0]     t_rise;
  logic [CH-1:0]     t_fall;
  logic [CH-1:0]     t_evt;
  logic [CH-1:0]     edge_flag;
  logic [CH-1:0]     ovr;

  modport master (
    output t, filt_len, edge_sel, flag_clr,
    input  t_filt, t_rise, t_fall, t_evt, edge_flag, ovr
  );

  modport slave (
    input  t, filt_len, edge_sel, flag_clr,
    output t_filt, t_rise, t_fall, t_evt, edge_flag, ovr
  );
endinterface

// File: rtl/ext_sync_filter.sv
// Per-channel pin synchroniser + glitch filter + edge detect + sticky event/overrun flags.
// Edge pulses appear after sync edge SYNC_STAGES+filt_len+1; no backpressure, events are never stalled.
module ext_sync_filter #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  ext_sync_filter_if.slave bus
);
  localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync [CH];
  logic [FILT_W-1:0]      r_cnt  [CH];
  logic [CH-1:0]          r_f;
  logic [CH-1:0]          r_fd;
  logic [CH-1:0]          r_flag;
  logic [CH-1:0]          r_ovr;
  logic [CH-1:0]          w_ts;
  logic [CH-1:0]          w_rise;
  logic [CH-1:0]          w_fall;
  logic [CH-1:0]          w_evt;

  assign w_rise = r_f & ~r_fd;
  assign w_fall = ~r_f & r_fd;

  always_comb begin
    w_ts  = '0;
    w_evt = '0;
    for (int i = 0; i < CH; i++) begin
      w_ts[i]  = r_sync[i][SYNC_STAGES-1];
      w_evt[i] = (bus.edge_sel[2*i] & w_rise[i]) | (bus.edge_sel[2*i+1] & w_fall[i]);
    end
  end

  // The >= compare lets a lowered filt_len cut a running count short instead of wrapping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_f  <= '0;
      r_fd <= '0;
    end else begin
      r_fd <= r_f;
      for (int i = 0; i < CH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], bus.t[i]};
        if (w_ts[i] == r_f[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= bus.filt_len) begin
          r_f[i]   <= w_ts[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // A new event beats a same-cycle clear; with a pending flag the clear consumes the old event.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_flag <= '0;
      r_ovr  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (w_evt[i]) begin
          r_flag[i] <= 1'b1;
          if (r_flag[i] && !bus.flag_clr[i]) begin
            r_ovr[i] <= 1'b1;
          end
        end else if (bus.flag_clr[i]) begin
          r_flag[i] <= 1'b0;
          r_ovr[i]  <= 1'b0;
        end
      end
    end
  end

  assign bus.t_filt    = r_f;
  assign bus.t_rise    = w_rise;
  assign bus.t_fall    = w_fall;
  assign bus.t_evt     = w_evt;
  assign bus.edge_flag = r_flag;
  assign bus.ovr       = r_ovr;
endmodule

// File: doc/ext_sync_filter.md
Name: ext_sync_filter

Overview:
- Multi-channel successor to the prescaler external-clock synchroniser: brings CH asynchronous external pins into the sys_clk domain.
- Each channel has a parametrised-depth synchroniser chain, a programmable glitch filter, and rise/fall/both edge selection.
- Each channel also keeps a sticky event flag with overrun detection.
- Feeds timer/counter prescaler clock-select logic and pin-change style interrupt sources.

Parameters:
- CH, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILT_W, 4, width of filter length and per-channel filter counter.

Ports:
- sys_clk  input  1  system clock; all state updates on posedge.
- sys_rst_n  input  1  reset, asynchronous, active-low; clears all state immediately.
- t  input  CH  raw asynchronous external inputs, one bit per channel.
- filt_len  input  FILT_W  shared filter length m; 0 = filter bypass.
- edge_sel  input  2*CH  per-channel event select, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both.
- flag_clr  input  CH  per-channel single-cycle clear of edge_flag and ovr.
- t_filt  output  CH  filtered, synchronised level.
- t_rise  output  CH  one-cycle pulse on filtered rising edge.
- t_fall  output  CH  one-cycle pulse on filtered falling edge.
- t_evt  output  CH  one-cycle pulse on the selected edge(s).
- edge_flag  output  CH  sticky event-pending flag.
- ovr  output  CH  sticky overrun flag.

Behaviour:
- Reset: every sync flop, filter state f, delayed state f_d, counter, edge_flag and ovr go to 0. All outputs are 0 during and directly after reset.
- An input already high at reset release produces one t_rise after the normal latency. This is intended.
- Channels are fully independent and identical; each uses only its own slice of t, edge_sel and flag_clr.
- Sync: t_s = last flop of a SYNC_STAGES shift chain; no logic between stages. Edge 1 is the first posedge sampling a new level; t_s shows it after edge SYNC_STAGES.
- Filter (per channel, registers f and cnt):
  - t_s == f: cnt <= 0.
  - t_s != f and cnt >= filt_len: f <= t_s, cnt <= 0.
  - t_s != f otherwise: cnt <= cnt + 1.
- Filter consequences:
  - A change is accepted after t_s differs for m+1 consecutive cycles.
  - A pulse lasting <= m cycles at t_s is fully suppressed; cnt returns to 0.
  - The >= compare means lowering filt_len mid-count takes effect immediately. cnt can never exceed the largest filt_len seen, so no wrap occurs.
  - filt_len = 0: f follows t_s one cycle later.
- t_filt = f.
- Edges: f_d <= f each cycle.
  - t_rise = f & ~f_d; t_fall = ~f & f_d.
  - Latency: t_rise/t_fall is high only in the cycle after edge SYNC_STAGES+m+1 (after edge 3 for defaults, m=0).
  - Pulse width is exactly 1 cycle. t_rise and t_fall are never high together.
- t_evt = (edge_sel[0] & t_rise) | (edge_sel[1] & t_fall); combinational from registered f/f_d.
- Flags (registered):
  - t_evt=1: edge_flag <= 1, even if flag_clr is high the same cycle (set wins).
  - t_evt=0, flag_clr=1: edge_flag <= 0.
  - ovr <= 1 when t_evt=1, edge_flag=1 and flag_clr=0.
  - Otherwise flag_clr=1 clears ovr.
  - t_evt, edge_flag=1 and flag_clr=1 in the same cycle: the old event is consumed; edge_flag stays 1, ovr is unchanged.
- Changing edge_sel affects t_evt from the same cycle; flags are not retroactively set.
- Asynchronous reset mid-filter or mid-pulse aborts everything; no pulse is emitted for the aborted transition.

Test Plan:
- Defaults, m=0: hold t[0]=1 from edge 1 -> t_rise[0]=1 only in cycle after edge 3; t_filt[0]=1 from then; drop t[0] -> t_fall[0] pulse 3 cycles after its first sampling edge.
- m=3: 3-cycle high glitch on t[1] -> no t_filt/t_rise change, cnt back to 0; a 4-cycle high pulse -> t_rise[1] at edge SYNC_STAGES+4 after start, one cycle wide.
- edge_sel ch2=11, square wave with period 16 cycles -> t_evt[2] on both edges, 8 cycles apart; edge_sel=00 -> t_evt[2] never high, t_rise/t_fall still pulse.
- Flags: event -> edge_flag=1; second event without clear -> ovr=1; flag_clr alone -> both 0; flag_clr coincident with new event -> edge_flag=1, ovr unchanged.
- Assert sys_rst_n low asynchronously mid-count (cnt=2, m=5) -> all outputs 0 immediately. Release with t=1 -> single t_rise after full latency.
- SYNC_STAGES=3, CH=8, random independent inputs vs reference model -> per-channel outputs match cycle-exactly; no cross-channel interaction.
